// File: rtl/sequential_multiplier.sv
// Shift-and-add multiplier, signed or unsigned, one iteration per clock.
// Optional macro SEQUENTIAL_MULTIPLIER_EARLY_EXIT_EN stops RUN once the multiplier shift register empties.
module sequential_multiplier #(
  parameter int BITS = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_signed,
  input  logic [BITS-1:0]   i_multiplicand,
  input  logic [BITS-1:0]   i_multiplier,
  output logic              o_busy,
  output logic              o_finished,
  output logic [2*BITS-1:0] o_product,
  output logic [1:0]        o_state
);

  localparam int CW = $clog2(BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [BITS-1:0]     r_mcand;
  logic [BITS-1:0]     r_mplier;
  logic [2*BITS-1:0]   r_acc;
  logic [CW-1:0]       r_count;
  logic                r_neg;

  logic [BITS-1:0]     w_mcand_mag;
  logic [BITS-1:0]     w_mplier_mag;
  logic [BITS:0]       w_sum;
  logic [2*BITS-1:0]   w_acc_next;
  logic [2*BITS-1:0]   w_aligned;
  logic [2*BITS-1:0]   w_negated;
  logic                w_last;

  // Magnitude of the most negative value still fits in BITS unsigned bits.
  assign w_mcand_mag  = (i_signed & i_multiplicand[BITS-1]) ? (~i_multiplicand + BITS'(1))
                                                            : i_multiplicand;
  assign w_mplier_mag = (i_signed & i_multiplier[BITS-1]) ? (~i_multiplier + BITS'(1))
                                                          : i_multiplier;

  assign w_sum      = {1'b0, r_acc[2*BITS-1:BITS]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
  assign w_acc_next = {w_sum, r_acc[BITS-1:1]};

`ifdef SEQUENTIAL_MULTIPLIER_EARLY_EXIT_EN
  // The partial product sits r_count bits too high when RUN ends early.
  assign w_last    = (r_count == CW'(1)) || (r_mplier[BITS-1:1] == '0);
  assign w_aligned = r_acc >> r_count;
`else
  assign w_last    = (r_count == CW'(1));
  assign w_aligned = r_acc;
`endif

  assign w_negated = ~w_aligned + (2*BITS)'(1);
  assign o_state   = r_state;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_count    <= '0;
      r_neg      <= 1'b0;
      o_busy     <= 1'b0;
      o_finished <= 1'b0;
      o_product  <= '0;
    end else begin
      o_finished <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mcand  <= w_mcand_mag;
            r_mplier <= w_mplier_mag;
            r_neg    <= i_signed & (i_multiplicand[BITS-1] ^ i_multiplier[BITS-1]);
            r_count  <= CW'(BITS);
            r_acc    <= '0;
            o_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc    <= w_acc_next;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count - CW'(1);
          if (w_last) r_state <= S_DONE;
        end
        S_DONE: begin
          // Negating a zero magnitude yields zero, so no -0 can appear.
          o_product  <= r_neg ? w_negated : w_aligned;
          o_busy     <= 1'b0;
          o_finished <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_multiplier.sv
// Scoreboard bench for sequential_multiplier (BITS=4): directed cases, exhaustive sweep, random traffic.
module tb_sequential_multiplier;

  localparam int BITS = 4;
  localparam int W    = 2 * BITS;

  logic            clk;
  logic            i_reset;
  logic            i_start;
  logic            i_signed;
  logic [BITS-1:0] i_multiplicand;
  logic [BITS-1:0] i_multiplier;
  logic            o_busy;
  logic            o_finished;
  logic [W-1:0]    o_product;
  logic [1:0]      o_state;

  sequential_multiplier #(.BITS(BITS)) dut (
    .i_clock        (clk),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_signed       (i_signed),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
    .o_busy         (o_busy),
    .o_finished     (o_finished),
    .o_product      (o_product),
    .o_state        (o_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // reference model: plain integer arithmetic
  function automatic int sval(input logic [BITS-1:0] x, input logic s);
    return s ? int'($signed(x)) : int'(x);
  endfunction

  function automatic logic [W-1:0] ref_product(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                                               input logic s);
    int p;
    p = sval(a, s) * sval(b, s);
    return W'(p);
  endfunction

  function automatic int ref_latency(input logic [BITS-1:0] b, input logic s);
`ifdef SEQUENTIAL_MULTIPLIER_EARLY_EXIT_EN
    int m;
    int k;
    m = sval(b, s);
    if (m < 0) m = -m;
    k = 0;
    while (m > 0) begin
      k++;
      m = m / 2;
    end
    return ((k < 1) ? 1 : k) + 1;
`else
    return BITS + 1;
`endif
  endfunction

  // monitor
  always @(negedge clk) begin
    if (o_finished) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_finished: got product %h at edge %0d, expected no result", o_product, cyc);
      end else begin
        check("product", o_product, exp_q.pop_front());
        check_int("finish_edge", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  // driver
  task automatic do_mul(input logic [BITS-1:0] a, input logic [BITS-1:0] b, input logic s,
                        input bit noise, input bit hold, input bit use_exp, input logic [W-1:0] exp_v);
    int n;
    int lat;
    @(negedge clk);
    i_start        = 1'b1;
    i_multiplicand = a;
    i_multiplier   = b;
    i_signed       = s;
    @(posedge clk);
    #1;
    n   = cyc;
    lat = ref_latency(b, s);
    exp_q.push_back(use_exp ? exp_v : ref_product(a, b, s));
    exp_cyc_q.push_back(n + lat);
    for (int e = 0; e < lat; e++) begin
      check("busy_high", W'(o_busy), W'(1));
      @(negedge clk);
      if (hold) begin
        if (e == 1) begin
          i_multiplicand = BITS'(2);
          i_multiplier   = BITS'(2);
        end
      end else if (noise) begin
        i_start        = 1'($urandom_range(0, 1));
        i_multiplicand = BITS'($urandom);
        i_multiplier   = BITS'($urandom);
        i_signed       = 1'($urandom_range(0, 1));
      end else begin
        i_start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    check("busy_low_at_finish", W'(o_busy), W'(0));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_start = 1'b0;
      @(posedge clk);
    end
  endtask

  initial begin
    i_reset        = 1'b1;
    i_start        = 1'b0;
    i_signed       = 1'b0;
    i_multiplicand = '0;
    i_multiplier   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", W'(o_busy), W'(0));
    check("reset_finished", W'(o_finished), W'(0));
    check("reset_product", o_product, W'(0));
    check("reset_state", W'(o_state), W'(0));
    @(negedge clk);
    i_reset = 1'b0;

    // directed values with spec-given results
    do_mul(4'd11, 4'd5, 1'b0, 0, 0, 1, 8'h37);
    do_mul(4'hD, 4'h5, 1'b1, 0, 0, 1, 8'hF1);
    do_mul(4'h8, 4'h8, 1'b1, 0, 0, 1, 8'h40);
    do_mul(4'hF, 4'hF, 1'b0, 0, 0, 1, 8'hE1);
    do_mul(4'd9, 4'd1, 1'b0, 0, 0, 1, 8'h09);
    do_mul(4'd9, 4'd0, 1'b0, 0, 0, 1, 8'h00);
    do_mul(4'd9, 4'd8, 1'b0, 0, 0, 1, 8'h48);
    do_mul(4'h0, 4'h8, 1'b1, 0, 0, 1, 8'h00);
    do_mul(4'h8, 4'h0, 1'b1, 0, 0, 1, 8'h00);
    // start held high with operands changed mid-run, then immediate next start
    do_mul(4'd13, 4'd10, 1'b0, 0, 1, 1, 8'h82);
    do_mul(4'd3, 4'd2, 1'b0, 0, 0, 1, 8'h06);
    idle(2);

    // reset aborts an in-flight multiply
    @(negedge clk);
    i_start        = 1'b1;
    i_multiplicand = 4'd7;
    i_multiplier   = 4'd7;
    i_signed       = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", W'(o_busy), W'(0));
    check("abort_finished", W'(o_finished), W'(0));
    check("abort_product", o_product, W'(0));
    @(negedge clk);
    i_reset = 1'b0;
    idle(8);
    do_mul(4'd3, 4'd3, 1'b0, 0, 0, 1, 8'h09);

    // exhaustive sweep, back-to-back, with ignored start noise while busy
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          do_mul(BITS'(a), BITS'(b), 1'(s), 1, 0, 0, '0);

    // random traffic with random gaps
    for (int i = 0; i < 200; i++) begin
      do_mul(BITS'($urandom), BITS'($urandom), 1'($urandom_range(0, 1)), 1, 0, 0, '0);
      idle($urandom_range(0, 2));
    end

    idle(12);
    while (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL missing_finished: got no result, expected %h", exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
